// File: rtl/cpu_pkg.sv
// Shared constants and ALU op encoding for the CPU datapath and its control FSM.
package cpu_pkg;
   localparam int D_WIDTH  = 16;
   localparam int PC_WIDTH = 7;
   localparam int RF_DEPTH = 16;
   localparam int DM_DEPTH = 256;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_XOR  = 3'd5,
      ALU_NOT  = 3'd6,
      ALU_SHL  = 3'd7
   } alu_op_e;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: pass/add/sub always; logic and shift ops only with CPU_DP_ALU_EXT_EN.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [2:0]   ALU_s0,
   output logic [W-1:0] result
);
   always_comb begin
      result = '0;
      case (alu_op_e'(ALU_s0))
         ALU_PASS: result = A;
         ALU_ADD:  result = A + B;
         ALU_SUB:  result = A - B;
`ifdef CPU_DP_ALU_EXT_EN
         ALU_AND:  result = A & B;
         ALU_OR:   result = A | B;
         ALU_XOR:  result = A ^ B;
         ALU_NOT:  result = ~A;
         ALU_SHL:  result = A << 1;
`endif
         default:  result = '0;
      endcase
   end
endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: PC, IR, 16-entry register file, 256-word data memory and ALU.
// Optional extended ALU ops are enabled by defining CPU_DP_ALU_EXT_EN.
module cpu_datapath #(
   parameter int D_WIDTH  = cpu_pkg::D_WIDTH,
   parameter int PC_WIDTH = cpu_pkg::PC_WIDTH
) (
   input  logic                Clock,
   input  logic                ResetN,
   input  logic                PC_clr,
   input  logic                IR_Id,
   input  logic                PC_up,
   input  logic [7:0]          D_addr,
   input  logic                D_wr,
   input  logic                RF_s,
   input  logic [3:0]          RF_Ra_addr,
   input  logic [3:0]          RF_Rb_addr,
   input  logic                RF_W_en,
   input  logic [3:0]          RF_W_addr,
   input  logic [2:0]          ALU_s0,
   input  logic [D_WIDTH-1:0]  I_data,
   output logic [PC_WIDTH-1:0] I_addr,
   output logic [D_WIDTH-1:0]  IR,
   output logic [D_WIDTH-1:0]  ALU_out
);
   import cpu_pkg::*;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [D_WIDTH-1:0]  ir_q, ir_d;
   logic [D_WIDTH-1:0]  rdata_q;
   logic [D_WIDTH-1:0]  rf_q  [RF_DEPTH];
   logic [D_WIDTH-1:0]  mem_q [DM_DEPTH];
   logic [D_WIDTH-1:0]  rf_a, rf_b, rf_wdata_d;

   assign rf_a       = rf_q[RF_Ra_addr];
   assign rf_b       = rf_q[RF_Rb_addr];
   assign rf_wdata_d = RF_s ? rdata_q : ALU_out;
   assign I_addr     = pc_q;
   assign IR         = ir_q;

   cpu_alu #(.W(D_WIDTH)) u_alu (
      .A      (rf_a),
      .B      (rf_b),
      .ALU_s0 (ALU_s0),
      .result (ALU_out)
   );

   always_comb begin
      pc_d = pc_q;
      if (PC_clr)     pc_d = '0;
      else if (PC_up) pc_d = pc_q + 1'b1;
      ir_d = IR_Id ? I_data : ir_q;
   end

   // Register-file reads are combinational and see the pre-write value (no bypass).
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         pc_q    <= '0;
         ir_q    <= '0;
         rdata_q <= '0;
         for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         rdata_q <= mem_q[D_addr];
         if (RF_W_en) rf_q[RF_W_addr] <= rf_wdata_d;
      end
   end

   // Memory contents survive reset; writes are simply blocked while ResetN is low.
   always_ff @(posedge Clock) begin
      if (D_wr && ResetN) mem_q[D_addr] <= rf_a;
   end
endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed sequences, a vector table and random traffic.
module tb_cpu_datapath;
   logic        Clock = 1'b0;
   logic        ResetN, PC_clr, IR_Id, PC_up, D_wr, RF_s, RF_W_en;
   logic [7:0]  D_addr;
   logic [3:0]  RF_Ra_addr, RF_Rb_addr, RF_W_addr;
   logic [2:0]  ALU_s0;
   logic [15:0] I_data;
   logic [6:0]  I_addr;
   logic [15:0] IR, ALU_out;

`ifdef CPU_DP_ALU_EXT_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] m_rf  [16];
   logic [15:0] m_mem [256];
   logic [15:0] m_rdata, m_ir;
   int          m_pc;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_base;
      logic [15:0] exp_ext;
   } vec_t;
   vec_t vecs [10];

   cpu_datapath dut (
      .Clock(Clock), .ResetN(ResetN), .PC_clr(PC_clr), .IR_Id(IR_Id), .PC_up(PC_up),
      .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_Ra_addr(RF_Ra_addr),
      .RF_Rb_addr(RF_Rb_addr), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr),
      .ALU_s0(ALU_s0), .I_data(I_data), .I_addr(I_addr), .IR(IR), .ALU_out(ALU_out)
   );

   always #5 Clock = ~Clock;

   function automatic logic [15:0] alu_ref(input int op, input logic [15:0] a, input logic [15:0] b);
      int r;
      case (op)
         0: r = a;
         1: r = (a + b) % 65536;
         2: r = (a - b + 65536) % 65536;
         3: r = EXT ? (a & b) : 0;
         4: r = EXT ? (a | b) : 0;
         5: r = EXT ? (a ^ b) : 0;
         6: r = EXT ? (65535 - a) : 0;
         default: r = EXT ? ((a * 2) % 65536) : 0;
      endcase
      return 16'(r);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      PC_clr = 0; IR_Id = 0; PC_up = 0; D_wr = 0; RF_s = 0; RF_W_en = 0;
      D_addr = 0; RF_Ra_addr = 0; RF_Rb_addr = 0; RF_W_addr = 0; ALU_s0 = 0; I_data = 0;
   endtask

   task automatic model_update();
      logic [15:0] a, b, wd, nr;
      a  = m_rf[RF_Ra_addr];
      b  = m_rf[RF_Rb_addr];
      wd = RF_s ? m_rdata : alu_ref(ALU_s0, a, b);
      nr = m_mem[D_addr];
      if (D_wr) m_mem[D_addr] = a;
      if (RF_W_en) m_rf[RF_W_addr] = wd;
      m_rdata = nr;
      if (PC_clr) m_pc = 0;
      else if (PC_up) m_pc = (m_pc + 1) % 128;
      if (IR_Id) m_ir = I_data;
   endtask

   task automatic step();
      model_update();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [15:0] pcv;
      pcv = 16'(m_pc);
      chk({tag, "_pc"}, {9'd0, I_addr}, pcv);
      chk({tag, "_ir"}, IR, m_ir);
      chk({tag, "_alu"}, ALU_out, alu_ref(ALU_s0, m_rf[RF_Ra_addr], m_rf[RF_Rb_addr]));
   endtask

   task automatic poke(input logic [7:0] addr, input logic [15:0] val);
      dut.mem_q[addr] = val;
      m_mem[addr] = val;
   endtask

   task automatic load_reg(input logic [3:0] r, input logic [7:0] addr, input logic [15:0] val);
      poke(addr, val);
      D_wr = 0; D_addr = addr; RF_s = 1; RF_W_en = 0;
      step();
      RF_W_en = 1; RF_W_addr = r;
      step();
      RF_W_en = 0; RF_s = 0;
   endtask

   initial begin
      vecs[0] = '{3'd1, 16'hFFFF, 16'h0002, 16'h0001, 16'h0001};
      vecs[1] = '{3'd2, 16'h0002, 16'hFFFF, 16'h0003, 16'h0003};
      vecs[2] = '{3'd5, 16'hFFFF, 16'h0002, 16'h0000, 16'hFFFD};
      vecs[3] = '{3'd0, 16'h1234, 16'h5678, 16'h1234, 16'h1234};
      vecs[4] = '{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF};
      vecs[5] = '{3'd1, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
      vecs[6] = '{3'd3, 16'hF0F0, 16'hFF00, 16'h0000, 16'hF000};
      vecs[7] = '{3'd4, 16'hF0F0, 16'h0F0F, 16'h0000, 16'hFFFF};
      vecs[8] = '{3'd6, 16'h00FF, 16'h0000, 16'h0000, 16'hFF00};
      vecs[9] = '{3'd7, 16'h8001, 16'h0000, 16'h0000, 16'h0002};

      ResetN = 0;
      idle();
      for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom));
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_rdata = '0; m_ir = '0; m_pc = 0;

      // Reset state
      #2;
      chk("rst_iaddr", {9'd0, I_addr}, 16'h0000);
      chk("rst_ir", IR, 16'h0000);
      chk("rst_alu", ALU_out, 16'h0000);
      @(posedge Clock); #1;
      ResetN = 1;

      // PC increment, clear priority, wrap
      PC_up = 1;
      repeat (3) step();
      chk("pc_up3", {9'd0, I_addr}, 16'd3);
      PC_clr = 1;
      step();
      chk("pc_clr_prio", {9'd0, I_addr}, 16'd0);
      PC_clr = 0;
      repeat (127) step();
      chk("pc_127", {9'd0, I_addr}, 16'd127);
      step();
      chk("pc_wrap", {9'd0, I_addr}, 16'd0);

      // IR load together with PC increment
      repeat (5) step();
      chk("pc_5", {9'd0, I_addr}, 16'd5);
      I_data = 16'h2153; IR_Id = 1;
      step();
      chk("ir_load", IR, 16'h2153);
      chk("ir_pc6", {9'd0, I_addr}, 16'd6);
      idle();
      I_data = 16'hDEAD;
      step();
      chk("ir_hold", IR, 16'h2153);

      // Two-cycle load then store with read-first check
      load_reg(4'd3, 8'h15, 16'h00AB);
      RF_Ra_addr = 3; ALU_s0 = 0; #1;
      chk("load_r3", ALU_out, 16'h00AB);
      poke(8'h35, 16'h1111);
      D_wr = 1; D_addr = 8'h35;
      step();
      D_wr = 0; RF_s = 1; RF_W_en = 1; RF_W_addr = 5;
      step();
      RF_W_addr = 6;
      step();
      RF_W_en = 0; RF_s = 0; RF_Ra_addr = 5; #1;
      chk("rd_old", ALU_out, 16'h1111);
      RF_Ra_addr = 6; #1;
      chk("st_new", ALU_out, 16'h00AB);
      check_all("st");

      // ALU vector table, result also written back to R4
      for (int v = 0; v < 10; v++) begin
         logic [15:0] exp;
         exp = EXT ? vecs[v].exp_ext : vecs[v].exp_base;
         load_reg(4'd2, 8'hE2, vecs[v].a);
         load_reg(4'd3, 8'hE3, vecs[v].b);
         RF_Ra_addr = 2; RF_Rb_addr = 3; ALU_s0 = vecs[v].op; #1;
         chk($sformatf("vec%0d_alu", v), ALU_out, exp);
         RF_W_en = 1; RF_W_addr = 4; RF_s = 0;
         step();
         RF_W_en = 0; RF_Ra_addr = 4; ALU_s0 = 0; #1;
         chk($sformatf("vec%0d_wb", v), ALU_out, exp);
      end

      // Random traffic against the reference model
      for (int it = 0; it < 400; it++) begin
         PC_clr = ($urandom_range(0, 15) == 0);
         PC_up = 1'($urandom_range(0, 1));
         IR_Id = 1'($urandom_range(0, 1));
         I_data = 16'($urandom);
         D_addr = 8'($urandom_range(0, 31));
         D_wr = ($urandom_range(0, 3) == 0);
         RF_s = 1'($urandom_range(0, 1));
         RF_Ra_addr = 4'($urandom);
         RF_Rb_addr = 4'($urandom);
         RF_W_en = 1'($urandom_range(0, 1));
         RF_W_addr = 4'($urandom);
         ALU_s0 = 3'($urandom);
         #1;
         chk("rnd_alu_pre", ALU_out, alu_ref(ALU_s0, m_rf[RF_Ra_addr], m_rf[RF_Rb_addr]));
         step();
         check_all($sformatf("rnd%0d", it));
      end

      // Reset asserted mid-cycle with a pending register write
      idle();
      load_reg(4'd7, 8'hF7, 16'hBEEF);
      PC_clr = 1;
      step();
      PC_clr = 0; PC_up = 1; IR_Id = 1; I_data = 16'hA5A5;
      step();
      chk("pre_rst_pc", {9'd0, I_addr}, 16'd1);
      chk("pre_rst_ir", IR, 16'hA5A5);
      idle();
      RF_W_en = 1; RF_W_addr = 7; RF_Ra_addr = 7; ALU_s0 = 1; PC_up = 1;
      #3;
      ResetN = 0;
      #1;
      chk("mid_rst_pc", {9'd0, I_addr}, 16'd0);
      chk("mid_rst_ir", IR, 16'h0000);
      chk("mid_rst_alu", ALU_out, 16'h0000);
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_rdata = '0; m_ir = '0; m_pc = 0;
      @(posedge Clock); #1;
      chk("in_rst_r7", ALU_out, 16'h0000);
      chk("in_rst_pc", {9'd0, I_addr}, 16'd0);
      idle();
      ResetN = 1;
      step();
      RF_Ra_addr = 7; #1;
      chk("post_rst_r7", ALU_out, 16'h0000);
      check_all("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
